icache_direct: RTL and testbench

Direct-mapped, read-only instruction cache between the core's instruction bus (ibus) and the instruction-side ibus-to-cbus path into the CBus arbiter. It replaces the pass-through converter on the fetch side. Hits return in the request cycle. Misses issue one incrementing CBus burst for the whole line. Addresses below 0x8000_0000 are treated as uncached MMIO and bypass the array with a single-beat read.

---
 rtl/icache_direct.sv | 176 +++++++++++++++++
 tb/tb_icache_direct.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache between the core ibus and the CBus arbiter.
// Hits answer combinationally; misses refill a whole line with one INCR burst; addr[31]=0 bypasses.
package icache_direct_pkg;
   localparam logic [2:0] MSIZE4     = 3'd2;
   localparam logic [2:0] MSIZE8     = 3'd3;
   localparam logic [1:0] BURST_INCR = 2'd1;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [63:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      logic [7:0]  len;
      logic [1:0]  burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;
endpackage

module icache_direct
   import icache_direct_pkg::*;
#(
   parameter int unsigned LINES      = 16,
   parameter int unsigned LINE_BEATS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  ibus_req_t  ireq,
   output ibus_resp_t iresp,
   input  logic       flush,
   output cbus_req_t  creq,
   input  cbus_resp_t cresp
);
   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned OFF_W = $clog2(LINE_BEATS);
   localparam int unsigned LO_W  = 3 + OFF_W;
   localparam int unsigned TAG_W = 64 - LO_W - IDX_W;

   typedef enum logic [1:0] {IDLE, REFILL, BYPASS, RESP} state_t;

   state_t            state_q, state_d;
   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [63:0]       data_q [LINES][LINE_BEATS];
   logic [63:0]       addr_q;
   logic [OFF_W-1:0]  k_q;
   logic              killed_q;
   logic [31:0]       rdata_q;

   logic [IDX_W-1:0]  req_idx, fill_idx;
   logic [TAG_W-1:0]  req_tag, fill_tag;
   logic [OFF_W-1:0]  req_beat, fill_beat;
   logic [63:0]       hit_beat;
   logic [31:0]       beat_half;
   logic              hit;
   logic              unused_addr;

   // Lookup on the live request; refill bookkeeping on the latched address
   assign req_idx     = ireq.addr[LO_W +: IDX_W];
   assign req_tag     = ireq.addr[63 -: TAG_W];
   assign req_beat    = ireq.addr[3 +: OFF_W];
   assign hit_beat    = data_q[req_idx][req_beat];
   assign hit         = ireq.valid && ireq.addr[31] && valid_q[req_idx]
                        && (tag_q[req_idx] == req_tag);
   assign fill_idx    = addr_q[LO_W +: IDX_W];
   assign fill_tag    = addr_q[63 -: TAG_W];
   assign fill_beat   = addr_q[3 +: OFF_W];
   assign beat_half   = addr_q[2] ? cresp.data[63:32] : cresp.data[31:0];
   assign unused_addr = ^ireq.addr[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      iresp   = '0;
      creq    = '0;
      unique case (state_q)
         IDLE: begin
            if (hit) begin
               iresp.addr_ok = 1'b1;
               iresp.data_ok = 1'b1;
               iresp.data    = ireq.addr[2] ? hit_beat[63:32] : hit_beat[31:0];
            end else if (ireq.valid) begin
               state_d = ireq.addr[31] ? REFILL : BYPASS;
            end
         end
         REFILL: begin
            creq.valid = 1'b1;
            creq.size  = MSIZE8;
            creq.addr  = {addr_q[63:LO_W], LO_W'(0)};
            creq.len   = 8'(LINE_BEATS - 1);
            creq.burst = BURST_INCR;
            if (cresp.ready && cresp.last) state_d = RESP;
         end
         BYPASS: begin
            creq.valid = 1'b1;
            creq.size  = MSIZE4;
            creq.addr  = addr_q;
            creq.burst = BURST_INCR;
            if (cresp.ready) state_d = RESP;
         end
         RESP: begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = rdata_q;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state: latched address, beat counter, kill flag, captured word, valid bits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q  <= '0;
         addr_q   <= '0;
         k_q      <= '0;
         killed_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ireq.valid && !hit) begin
                  addr_q   <= ireq.addr;
                  k_q      <= '0;
                  killed_q <= 1'b0;
               end
            end
            REFILL: begin
               if (flush) killed_q <= 1'b1;
               if (cresp.ready) begin
                  k_q <= k_q + OFF_W'(1);
                  if (k_q == fill_beat) rdata_q <= beat_half;
               end
            end
            BYPASS: begin
               if (cresp.ready) rdata_q <= beat_half;
            end
            default: ;
         endcase
         // A flush sampled on the final beat must also keep the line invalid
         if (flush)
            valid_q <= '0;
         else if (state_q == REFILL && cresp.ready && cresp.last && !killed_q)
            valid_q[fill_idx] <= 1'b1;
      end
   end

   // Line storage has no reset; valid_q guards it
   always_ff @(posedge clk) begin
      if (state_q == REFILL && cresp.ready) begin
         data_q[fill_idx][k_q] <= cresp.data;
         if (cresp.last) tag_q[fill_idx] <= fill_tag;
      end
   end
endmodule

// File: tb/tb_icache_direct.sv
// Randomized scoreboard bench for icache_direct: reference cache model, memory-backed arbiter model,
// and a monitor that pops expected fetch responses whenever data_ok is seen.
module tb_icache_direct;
   import icache_direct_pkg::*;

   localparam int unsigned    LINES      = 16;
   localparam int unsigned    LINE_BEATS = 4;
   localparam longint unsigned LINE_BYTES = 8 * LINE_BEATS;

   typedef struct {
      logic [31:0] data;
      bit          hit;
      int          cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   ibus_req_t  ireq;
   ibus_resp_t iresp;
   cbus_req_t  creq;
   cbus_resp_t cresp;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int txn_beats = 0;

   exp_t      exp_resp[$];
   cbus_req_t exp_bus[$];

   bit          mvalid[LINES];
   logic [63:0] mtag[LINES];

   icache_direct #(.LINES(LINES), .LINE_BEATS(LINE_BEATS)) dut (
      .clk(clk), .reset(rst_n), .ireq(ireq), .iresp(iresp),
      .flush(flush), .creq(creq), .cresp(cresp)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [63:0] mem64(input logic [63:0] a);
      logic [63:0] b;
      b = a >> 3;
      return {32'(b * 64'h9E37_79B1) ^ b[63:32], b[31:0] ^ b[63:32] ^ 32'h5A5A_0F0F};
   endfunction

   function automatic logic [31:0] word_at(input logic [63:0] a);
      logic [63:0] d;
      d = mem64(a);
      return a[2] ? d[63:32] : d[31:0];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < int'(LINES); i++) mvalid[i] = 1'b0;
   endtask

   // Arbiter + memory: checks each new request, holds it stable, returns beats with random stalls
   initial begin
      bit        in_txn, got_ready;
      int        beat;
      cbus_req_t cur, want;
      in_txn = 0; got_ready = 0; beat = 0; cur = '0;
      cresp = '0;
      forever begin
         @(negedge clk);
         cresp = '0;
         if (!rst_n) begin
            in_txn = 0; got_ready = 0; beat = 0; txn_beats = 0;
         end else if (!creq.valid) begin
            checks++;
            if (creq !== '0) begin
               errors++;
               $display("FAIL creq_idle got %h want 0", creq);
            end
         end else begin
            if (!in_txn) begin
               in_txn = 1; got_ready = 0; beat = 0; cur = creq;
               checks++;
               if (exp_bus.size() == 0) begin
                  errors++;
                  $display("FAIL creq_unexpected got addr %h want none", creq.addr);
               end else begin
                  want = exp_bus.pop_front();
                  if (creq !== want) begin
                     errors++;
                     $display("FAIL creq_fields got %h want %h", creq, want);
                  end
               end
            end else if (!got_ready) begin
               checks++;
               if (creq !== cur) begin
                  errors++;
                  $display("FAIL creq_stable got %h want %h", creq, cur);
               end
            end
            if ($urandom_range(0, 3) != 0) begin
               got_ready   = 1;
               cresp.ready = 1'b1;
               cresp.data  = mem64(cur.addr + 64'(beat) * 64'd8);
               cresp.last  = (beat == int'(cur.len));
               beat++;
               txn_beats = beat;
               if (cresp.last) begin
                  in_txn = 0;
                  txn_beats = 0;
               end
            end
         end
      end
   end

   // Monitor: every data_ok must match the oldest outstanding expected fetch
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && iresp.data_ok) begin
            checks++;
            if (exp_resp.size() == 0) begin
               errors++;
               $display("FAIL resp_unexpected got %h want none", iresp.data);
            end else begin
               e = exp_resp.pop_front();
               if (iresp.data !== e.data || iresp.addr_ok !== 1'b1) begin
                  errors++;
                  $display("FAIL resp_data got %h/%b want %h/1", iresp.data, iresp.addr_ok, e.data);
               end
               checks++;
               if (e.hit ? (cyc != e.cyc) : (cyc <= e.cyc + 1)) begin
                  errors++;
                  $display("FAIL resp_latency got cycle %0d want %s %0d", cyc,
                           e.hit ? "equal" : "after", e.cyc + 1);
               end
            end
         end
      end
   end

   // mode: 0 plain, 1 flush mid-refill, 2 reset mid-refill, 3 flush alongside the request
   task automatic fetch(input logic [63:0] a, input int mode_in);
      int          mode, idx, n;
      bit          hit, got, did;
      logic [63:0] tag;
      exp_t        e;
      cbus_req_t   b;
      mode = mode_in;
      idx  = int'((a / LINE_BYTES) % 64'(LINES));
      tag  = a / (LINE_BYTES * 64'(LINES));
      hit  = a[31] && mvalid[idx] && (mtag[idx] == tag);
      if ((mode == 1 || mode == 2) && (hit || !a[31])) mode = 0;
      if (mode == 3) clear_model();
      b = '0;
      b.valid = 1'b1;
      b.burst = BURST_INCR;
      if (!a[31]) begin
         b.size = MSIZE4; b.addr = a; b.len = 8'd0;
         exp_bus.push_back(b);
      end else if (!hit) begin
         b.size = MSIZE8; b.addr = a & ~(LINE_BYTES - 1); b.len = 8'(LINE_BEATS - 1);
         exp_bus.push_back(b);
         mvalid[idx] = 1'b1;
         mtag[idx]   = tag;
      end
      e.data = word_at(a); e.hit = hit; e.cyc = cyc;
      exp_resp.push_back(e);
      ireq.valid = 1'b1;
      ireq.addr  = a;
      flush      = (mode == 3);
      n = 0; did = 0;
      while (1) begin
         @(negedge clk);
         got = iresp.data_ok;
         @(posedge clk); #1;
         flush = 1'b0;
         if (got) break;
         if (mode == 1 && !did && txn_beats >= 2) begin
            flush = 1'b1; did = 1;
            clear_model();
         end
         if (mode == 2 && txn_beats >= 2) begin
            rst_n = 1'b0;
            #1;
            checks++;
            if (creq.valid !== 1'b0) begin
               errors++;
               $display("FAIL rst_creq_valid got %b want 0", creq.valid);
            end
            checks++;
            if (iresp !== '0) begin
               errors++;
               $display("FAIL rst_iresp got %h want 0", iresp);
            end
            void'(exp_resp.pop_back());
            clear_model();
            ireq.valid = 1'b0;
            @(posedge clk); @(posedge clk); #1;
            rst_n = 1'b1;
            break;
         end
         n++;
         if (n > 400) begin
            checks++; errors++;
            $display("FAIL fetch_timeout got no data_ok want data_ok for %h", a);
            break;
         end
      end
      ireq.valid = 1'b0;
   endtask

   initial begin
      logic [63:0] a;
      int          r, mode;
      rst_n = 1'b0; flush = 1'b0; ireq = '0;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (creq !== '0) begin errors++; $display("FAIL reset_creq got %h want 0", creq); end
      checks++;
      if (iresp !== '0) begin errors++; $display("FAIL reset_iresp got %h want 0", iresp); end
      rst_n = 1'b1;
      @(posedge clk); #1;

      fetch(64'h8000_0000, 0);   // cold miss
      fetch(64'h8000_001C, 0);   // hit, beat 3 upper half
      fetch(64'h8000_0200, 0);   // conflict
      fetch(64'h8000_0000, 0);   // misses again
      fetch(64'h1000_0004, 0);   // bypass
      fetch(64'h1000_0004, 0);   // bypass again
      fetch(64'h8000_0040, 1);   // flush during refill
      fetch(64'h8000_0040, 0);   // must miss
      fetch(64'h8000_0060, 2);   // reset during refill
      fetch(64'h8000_0060, 0);   // full burst re-issued
      fetch(64'h8000_0064, 3);   // hit answered during flush
      fetch(64'h8000_0068, 0);   // miss after that flush

      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)
            a = 64'h1000_0000 + 64'(4 * $urandom_range(0, 255));
         else
            a = ((r == 1) ? 64'h1_8000_0000 : 64'h8000_0000)
                + 64'(32 * $urandom_range(0, 47)) + 64'(4 * $urandom_range(0, 7));
         r = int'($urandom_range(0, 19));
         mode = (r < 4) ? r : 0;
         fetch(a, mode);
         if ($urandom_range(0, 24) == 0) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            clear_model();
         end
      end

      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (exp_resp.size() != 0) begin
         errors++;
         $display("FAIL resp_leftover got %0d want 0", exp_resp.size());
      end
      checks++;
      if (exp_bus.size() != 0) begin
         errors++;
         $display("FAIL bus_leftover got %0d want 0", exp_bus.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
